fp_result_queue: RTL and testbench

FP_RESULT_QUEUE -- requirements
Module: fp_result_queue

---
 rtl/fp_result_queue.sv | 160 ++++++++++++++++
 tb/tb_fp_result_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_queue.sv
// In-order FPU result tracker: queues issued destinations, pairs them with FPU results,
// drives a one-entry writeback register. Optional sticky flags via FP_RESULT_QUEUE_FFLAGS_EN.
module fp_result_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        issue_valid_i,
   input  logic [4:0]  issue_rd_i,
   input  logic        issue_to_int_i,
   output logic        issue_ready_o,
   input  logic        fpu_out_valid_i,
   input  logic [31:0] fpu_result_i,
   input  logic [4:0]  fpu_status_i,
   output logic        fpu_out_ready_o,
   input  logic        flush_i,
   output logic        wb_valid_o,
   output logic [4:0]  wb_rd_o,
   output logic        wb_to_int_o,
   output logic [31:0] wb_data_o,
   input  logic        wb_ready_i,
   input  logic [14:0] hz_raddr_i,
   output logic        hz_o,
   output logic [4:0]  fflags_o,
   input  logic        fflags_clr_i
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;
   logic [4:0]      rd_mem     [DEPTH];
   logic            to_int_mem [DEPTH];

   logic            wb_valid_q, wb_valid_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic            wb_to_int_q, wb_to_int_d;
   logic [31:0]     wb_data_q, wb_data_d;

   logic            full, empty, push, pop;
   logic [PtrW-1:0] idx;

   function automatic logic rd_hit(input logic [4:0] rd, input logic [14:0] raddr);
      return (rd == raddr[4:0]) || (rd == raddr[9:5]) || (rd == raddr[14:10]);
   endfunction

   assign full  = (count_q == CntW'(DEPTH));
   assign empty = (count_q == '0);

   assign issue_ready_o   = !full;
   assign fpu_out_ready_o = !empty && (!wb_valid_q || wb_ready_i);

   // Handshakes that coincide with a flush are dropped.
   assign push = issue_valid_i && issue_ready_o && !flush_i;
   assign pop  = fpu_out_valid_i && fpu_out_ready_o && !flush_i;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + PtrW'(1);
         if (pop)  head_d = head_q + PtrW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_comb begin
      wb_valid_d  = wb_valid_q;
      wb_rd_d     = wb_rd_q;
      wb_to_int_d = wb_to_int_q;
      wb_data_d   = wb_data_q;
      if (flush_i) begin
         wb_valid_d = 1'b0;
      end else if (pop) begin
         wb_valid_d  = 1'b1;
         wb_rd_d     = rd_mem[head_q];
         wb_to_int_d = to_int_mem[head_q];
         wb_data_d   = fpu_result_i;
      end else if (wb_ready_i) begin
         wb_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_to_int_q <= 1'b0;
         wb_data_q   <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_to_int_q <= wb_to_int_d;
         wb_data_q   <= wb_data_d;
      end
   end

   // Entry storage needs no reset: occupancy is tracked by the count alone.
   always_ff @(posedge clk_i) begin
      if (push) begin
         rd_mem[tail_q]     <= issue_rd_i;
         to_int_mem[tail_q] <= issue_to_int_i;
      end
   end

   always_comb begin
      hz_o = 1'b0;
      idx  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_q + PtrW'(i);
         if ((CntW'(i) < count_q) && !to_int_mem[idx] && rd_hit(rd_mem[idx], hz_raddr_i)) begin
            hz_o = 1'b1;
         end
      end
      if (wb_valid_q && !wb_to_int_q && rd_hit(wb_rd_q, hz_raddr_i)) hz_o = 1'b1;
   end

   assign wb_valid_o  = wb_valid_q;
   assign wb_rd_o     = wb_rd_q;
   assign wb_to_int_o = wb_to_int_q;
   assign wb_data_o   = wb_data_q;

`ifdef FP_RESULT_QUEUE_FFLAGS_EN
   logic [4:0] fflags_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fflags_q <= '0;
      end else if (fflags_clr_i) begin
         fflags_q <= pop ? fpu_status_i : 5'd0;
      end else if (pop) begin
         fflags_q <= fflags_q | fpu_status_i;
      end
   end

   assign fflags_o = fflags_q;
`else
   logic unused_fflags;

   assign unused_fflags = ^{fpu_status_i, fflags_clr_i};
   assign fflags_o      = '0;
`endif

endmodule

// File: tb/tb_fp_result_queue.sv
// Scoreboard bench for fp_result_queue: queue-based reference model, random plus directed
// stimulus, separate writeback monitor.
module tb_fp_result_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        issue_valid_i = 1'b0;
   logic [4:0]  issue_rd_i = '0;
   logic        issue_to_int_i = 1'b0;
   logic        issue_ready_o;
   logic        fpu_out_valid_i = 1'b0;
   logic [31:0] fpu_result_i = '0;
   logic [4:0]  fpu_status_i = '0;
   logic        fpu_out_ready_o;
   logic        flush_i = 1'b0;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic        wb_to_int_o;
   logic [31:0] wb_data_o;
   logic        wb_ready_i = 1'b0;
   logic [14:0] hz_raddr_i = '0;
   logic        hz_o;
   logic [4:0]  fflags_o;
   logic        fflags_clr_i = 1'b0;

   fp_result_queue #(.DEPTH(DEPTH)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .issue_valid_i  (issue_valid_i),
      .issue_rd_i     (issue_rd_i),
      .issue_to_int_i (issue_to_int_i),
      .issue_ready_o  (issue_ready_o),
      .fpu_out_valid_i(fpu_out_valid_i),
      .fpu_result_i   (fpu_result_i),
      .fpu_status_i   (fpu_status_i),
      .fpu_out_ready_o(fpu_out_ready_o),
      .flush_i        (flush_i),
      .wb_valid_o     (wb_valid_o),
      .wb_rd_o        (wb_rd_o),
      .wb_to_int_o    (wb_to_int_o),
      .wb_data_o      (wb_data_o),
      .wb_ready_i     (wb_ready_i),
      .hz_raddr_i     (hz_raddr_i),
      .hz_o           (hz_o),
      .fflags_o       (fflags_o),
      .fflags_clr_i   (fflags_clr_i)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // mq entry: {rd, to_int}; exp_q entry: {rd, to_int, data}
   logic [5:0]  mq[$];
   logic [37:0] exp_q[$];
   logic [4:0]  fflags_m = '0;
   logic        hs_pending = 1'b0;

   task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic hit(input logic [4:0] rd, input logic [14:0] ra);
      return (rd == ra[4:0]) || (rd == ra[9:5]) || (rd == ra[14:10]);
   endfunction

   function automatic logic model_hz(input logic [14:0] ra);
      logic h = 1'b0;
      foreach (mq[i]) if (!mq[i][0] && hit(mq[i][5:1], ra)) h = 1'b1;
      if (exp_q.size() != 0 && !exp_q[0][32] && hit(exp_q[0][37:33], ra)) h = 1'b1;
      return h;
   endfunction

   // Drive one cycle of stimulus, check combinational outputs, then advance the model.
   task automatic cycle(input logic iv, input logic [4:0] rd, input logic ti, input logic fv,
                        input logic [31:0] res, input logic [4:0] st, input logic wr,
                        input logic fl, input logic clr, input logic [14:0] ra);
      logic exp_ir, exp_or, push, pop;
      logic [5:0] e;
      issue_valid_i   = iv;
      issue_rd_i      = rd;
      issue_to_int_i  = ti;
      fpu_out_valid_i = fv;
      fpu_result_i    = res;
      fpu_status_i    = st;
      wb_ready_i      = wr;
      flush_i         = fl;
      fflags_clr_i    = clr;
      hz_raddr_i      = ra;
      @(negedge clk);
      exp_ir = (mq.size() != DEPTH);
      exp_or = (mq.size() != 0) && (exp_q.size() == 0 || wr);
      check("issue_ready", 38'(issue_ready_o), 38'(exp_ir));
      check("fpu_out_ready", 38'(fpu_out_ready_o), 38'(exp_or));
      check("hz", 38'(hz_o), 38'(model_hz(ra)));
      check("fflags", 38'(fflags_o), 38'(fflags_m));
      push = iv && exp_ir;
      pop  = fv && exp_or;
      @(posedge clk);
      if (fl) begin
         mq.delete();
         exp_q.delete();
      end else begin
         if (pop) begin
            e = mq.pop_front();
            exp_q.push_back({e, res});
         end
         if (push) mq.push_back({rd, ti});
      end
`ifdef FP_RESULT_QUEUE_FFLAGS_EN
      if (clr) fflags_m = (pop && !fl) ? st : 5'd0;
      else if (pop && !fl) fflags_m = fflags_m | st;
`endif
      #1;
   endtask

   task automatic idle(input logic wr);
      cycle(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 5'd0, wr, 1'b0, 1'b0, 15'd0);
   endtask

   task automatic rand_cycle(input int pi, input int pf, input int pw);
      cycle(($urandom_range(99) < 32'(pi)), 5'($urandom_range(7)), 1'($urandom),
            ($urandom_range(99) < 32'(pf)), $urandom, 5'($urandom),
            ($urandom_range(99) < 32'(pw)), ($urandom_range(99) < 2),
            ($urandom_range(99) < 6),
            {5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7))});
   endtask

   // Writeback monitor: compares the register against the scoreboard head.
   always @(negedge clk) begin
      if (!rst_ni) begin
         hs_pending = 1'b0;
      end else begin
         check("wb_valid", 38'(wb_valid_o), 38'(exp_q.size() != 0));
         if (exp_q.size() != 0 && wb_valid_o)
            check("wb_payload", {wb_rd_o, wb_to_int_o, wb_data_o}, exp_q[0]);
         hs_pending = (exp_q.size() != 0) && wb_ready_i;
      end
   end

   always @(posedge clk) begin
      if (hs_pending && exp_q.size() != 0) void'(exp_q.pop_front());
      hs_pending = 1'b0;
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wb_valid"}, 38'(wb_valid_o), 38'(0));
      check({tag, "_wb_fields"}, {wb_rd_o, wb_to_int_o, wb_data_o}, 38'(0));
      check({tag, "_issue_ready"}, 38'(issue_ready_o), 38'(1));
      check({tag, "_fpu_out_ready"}, 38'(fpu_out_ready_o), 38'(0));
      check({tag, "_fflags"}, 38'(fflags_o), 38'(0));
      check({tag, "_hz"}, 38'(hz_o), 38'(0));
   endtask

   initial begin
      #2;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1 rst_ni = 1'b1;

      // In-order pair: FP rd=3 then INT rd=7.
      cycle(1'b1, 5'd3, 1'b0, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 15'd0);
      cycle(1'b1, 5'd7, 1'b1, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, {5'd3, 5'd7, 5'd0});
      cycle(1'b0, 5'd0, 1'b0, 1'b1, 32'h3F80_0000, 5'h01, 1'b1, 1'b0, 1'b0, {5'd3, 5'd7, 5'd0});
      cycle(1'b0, 5'd0, 1'b0, 1'b1, 32'h4000_0000, 5'h10, 1'b1, 1'b0, 1'b0, {5'd3, 5'd7, 5'd0});
      idle(1'b1);
      cycle(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b1, 15'd0);

      // Fill to DEPTH, then attempt push alongside a pop.
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 5'(i + 1), 1'b0, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 15'd0);
      cycle(1'b1, 5'd9, 1'b0, 1'b1, 32'hAAAA_0001, 5'd0, 1'b1, 1'b0, 1'b0, 15'd0);
      cycle(1'b1, 5'd10, 1'b0, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 15'd0);

      // Backpressure: result offered while writeback stalls.
      cycle(1'b0, 5'd0, 1'b0, 1'b1, 32'hBBBB_0002, 5'd0, 1'b0, 1'b0, 1'b0, 15'd0);
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 5'd0, 1'b0, 1'b1, 32'hCCCC_0003, 5'd0, 1'b0, 1'b0, 1'b0, 15'd0);
      cycle(1'b0, 5'd0, 1'b0, 1'b1, 32'hDDDD_0004, 5'd0, 1'b1, 1'b0, 1'b0, 15'd0);

      // Flush with entries pending, then hazard on FP rd=5 vs INT rd=5.
      cycle(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 15'd0);
      idle(1'b1);
      cycle(1'b1, 5'd5, 1'b0, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, {5'd5, 5'd0, 5'd0});
      cycle(1'b1, 5'd5, 1'b1, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, {5'd5, 5'd0, 5'd0});
      cycle(1'b0, 5'd0, 1'b0, 1'b1, 32'h1111_0005, 5'd0, 1'b1, 1'b0, 1'b0, {5'd5, 5'd0, 5'd0});
      cycle(1'b0, 5'd0, 1'b0, 1'b1, 32'h2222_0006, 5'd0, 1'b1, 1'b0, 1'b0, {5'd5, 5'd0, 5'd0});
      cycle(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, {5'd5, 5'd0, 5'd0});
      cycle(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, {5'd5, 5'd0, 5'd0});

      // Random phases: fill-heavy, drain-heavy, stall-heavy, balanced.
      for (int ph = 0; ph < 4; ph++) begin
         for (int n = 0; n < 400; n++) begin
            case (ph)
               0:       rand_cycle(80, 20, 70);
               1:       rand_cycle(30, 80, 90);
               2:       rand_cycle(60, 60, 25);
               default: rand_cycle(50, 50, 60);
            endcase
         end
      end

      // Asynchronous reset in the middle of a burst.
      for (int n = 0; n < 6; n++) rand_cycle(90, 40, 30);
      rst_ni = 1'b0;
      issue_valid_i   = 1'b0;
      fpu_out_valid_i = 1'b0;
      flush_i         = 1'b0;
      fflags_clr_i    = 1'b0;
      #1;
      check_reset_outputs("midreset");
      mq.delete();
      exp_q.delete();
      fflags_m = '0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_ni = 1'b1;

      for (int n = 0; n < 300; n++) rand_cycle(50, 50, 60);
      for (int n = 0; n < 10; n++) cycle(1'b0, 5'd0, 1'b0, 1'b1, $urandom, 5'($urandom), 1'b1,
                                         1'b0, 1'b0, 15'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
